// File: rtl/trigger_pulse_generator.sv
// trigger_pulse_generator: armed trigger -> programmable delay -> train of
// programmable-width pulses, configured through the byte-wide register port.
module trigger_pulse_generator #(
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned WIDTH_W = 16
) (
  input  logic         sampleclk,
  input  logic         reset,
  input  logic         trigger_in,
  input  logic [7:0]   reg_cmd,
  input  logic [15:0]  reg_bytecount,
  input  logic [7:0]   reg_data_in,
  output logic [7:0]   reg_data_out,
  input  logic         reg_read,
  input  logic         reg_write,
  output logic         pulse_out,
  output logic         armed,
  output logic         busy
);

  localparam int unsigned DELAY_B = DELAY_W / 8;
  localparam int unsigned WIDTH_B = WIDTH_W / 8;
  localparam int unsigned COUNT_W = 8;

  localparam logic [7:0] ADDR_CTRL  = 8'h50;
  localparam logic [7:0] ADDR_DELAY = 8'h51;
  localparam logic [7:0] ADDR_WIDTH = 8'h52;
  localparam logic [7:0] ADDR_GAP   = 8'h53;
  localparam logic [7:0] ADDR_COUNT = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  // programmed configuration
  logic [DELAY_W-1:0] cfg_delay;
  logic [WIDTH_W-1:0] cfg_width;
  logic [WIDTH_W-1:0] cfg_gap;
  logic [COUNT_W-1:0] cfg_count;
  logic               auto_rearm;
  logic               done;
  logic               done_nx;

  // working counters, all hold "remaining minus one"
  logic [DELAY_W-1:0] dly_cnt;
  logic [DELAY_W-1:0] dly_cnt_nx;
  logic [WIDTH_W-1:0] wid_cnt;
  logic [WIDTH_W-1:0] wid_cnt_nx;
  logic [WIDTH_W-1:0] gap_cnt;
  logic [WIDTH_W-1:0] gap_cnt_nx;
  logic [COUNT_W-1:0] pls_cnt;
  logic [COUNT_W-1:0] pls_cnt_nx;

  // width/gap snapshot taken at trigger so the train is immune to later writes
  logic [WIDTH_W-1:0] wid_lat;
  logic [WIDTH_W-1:0] wid_lat_nx;
  logic [WIDTH_W-1:0] gap_lat;
  logic [WIDTH_W-1:0] gap_lat_nx;

  logic               busy_st;
  logic               ctrl_wr;
  logic               abort_c;
  logic               arm_c;
  logic               cfg_wr_en;
  logic [WIDTH_W-1:0] width_m1;
  logic [WIDTH_W-1:0] gap_m1;
  logic [COUNT_W-1:0] count_m1;
  state_t             finish_st;

  // control decode and effective (zero-mapped-to-one) configuration
  always_comb begin
    busy_st   = (state == ST_DELAY) || (state == ST_PULSE) || (state == ST_GAP);
    ctrl_wr   = reg_write && (reg_cmd == ADDR_CTRL) && (reg_bytecount == 16'd0);
    abort_c   = ctrl_wr && reg_data_in[1];
    arm_c     = ctrl_wr && reg_data_in[0] && !reg_data_in[1];
    cfg_wr_en = reg_write && !busy_st;
    width_m1  = (cfg_width == '0) ? '0 : cfg_width - WIDTH_W'(1);
    gap_m1    = (cfg_gap == '0) ? '0 : cfg_gap - WIDTH_W'(1);
    count_m1  = (cfg_count == '0) ? '0 : cfg_count - COUNT_W'(1);
    finish_st = auto_rearm ? ST_ARMED : ST_IDLE;
  end

  // configuration registers; byte lanes beyond a register's width are dropped
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      cfg_delay  <= '0;
      cfg_width  <= WIDTH_W'(1);
      cfg_gap    <= WIDTH_W'(1);
      cfg_count  <= COUNT_W'(1);
      auto_rearm <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        auto_rearm <= reg_data_in[2];
      end
      if (cfg_wr_en) begin
        for (int i = 0; i < DELAY_B; i++) begin
          if ((reg_cmd == ADDR_DELAY) && (reg_bytecount == 16'(i))) begin
            cfg_delay[i*8 +: 8] <= reg_data_in;
          end
        end
        for (int i = 0; i < WIDTH_B; i++) begin
          if ((reg_cmd == ADDR_WIDTH) && (reg_bytecount == 16'(i))) begin
            cfg_width[i*8 +: 8] <= reg_data_in;
          end
          if ((reg_cmd == ADDR_GAP) && (reg_bytecount == 16'(i))) begin
            cfg_gap[i*8 +: 8] <= reg_data_in;
          end
        end
        if ((reg_cmd == ADDR_COUNT) && (reg_bytecount == 16'd0)) begin
          cfg_count <= reg_data_in;
        end
      end
    end
  end

  // next-state and working-counter logic
  always_comb begin
    state_nx   = state;
    done_nx    = done;
    dly_cnt_nx = dly_cnt;
    wid_cnt_nx = wid_cnt;
    gap_cnt_nx = gap_cnt;
    pls_cnt_nx = pls_cnt;
    wid_lat_nx = wid_lat;
    gap_lat_nx = gap_lat;

    case (state)
      ST_IDLE: begin
        if (arm_c) begin
          state_nx = ST_ARMED;
          done_nx  = 1'b0;
        end
      end
      ST_ARMED: begin
        if (trigger_in) begin
          wid_lat_nx = width_m1;
          gap_lat_nx = gap_m1;
          wid_cnt_nx = width_m1;
          pls_cnt_nx = count_m1;
          if (cfg_delay == '0) begin
            state_nx = ST_PULSE;
          end else begin
            state_nx   = ST_DELAY;
            dly_cnt_nx = cfg_delay - DELAY_W'(1);
          end
        end
      end
      ST_DELAY: begin
        if (dly_cnt == '0) begin
          state_nx   = ST_PULSE;
          wid_cnt_nx = wid_lat;
        end else begin
          dly_cnt_nx = dly_cnt - DELAY_W'(1);
        end
      end
      ST_PULSE: begin
        if (wid_cnt == '0) begin
          if (pls_cnt != '0) begin
            state_nx   = ST_GAP;
            gap_cnt_nx = gap_lat;
            pls_cnt_nx = pls_cnt - COUNT_W'(1);
          end else begin
            state_nx = finish_st;
            done_nx  = 1'b1;
          end
        end else begin
          wid_cnt_nx = wid_cnt - WIDTH_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nx   = ST_PULSE;
          wid_cnt_nx = wid_lat;
        end else begin
          gap_cnt_nx = gap_cnt - WIDTH_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // abort overrides everything, including a finish landing on the same edge
    if (abort_c && (state != ST_IDLE)) begin
      state_nx = ST_IDLE;
      done_nx  = done;
    end
  end

  // state, counters and registered status outputs
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      dly_cnt   <= '0;
      wid_cnt   <= '0;
      gap_cnt   <= '0;
      pls_cnt   <= '0;
      wid_lat   <= '0;
      gap_lat   <= '0;
      pulse_out <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= done_nx;
      dly_cnt   <= dly_cnt_nx;
      wid_cnt   <= wid_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      pls_cnt   <= pls_cnt_nx;
      wid_lat   <= wid_lat_nx;
      gap_lat   <= gap_lat_nx;
      pulse_out <= (state_nx == ST_PULSE);
      armed     <= (state_nx == ST_ARMED);
      busy      <= (state_nx == ST_DELAY) || (state_nx == ST_PULSE) ||
                   (state_nx == ST_GAP);
    end
  end

  // combinational register readback
  always_comb begin
    reg_data_out = 8'h00;
    if (reg_read) begin
      case (reg_cmd)
        ADDR_CTRL: begin
          if (reg_bytecount == 16'd0) begin
            reg_data_out = {4'b0000, done, auto_rearm, busy_st, state == ST_ARMED};
          end
        end
        ADDR_DELAY: begin
          for (int i = 0; i < DELAY_B; i++) begin
            if (reg_bytecount == 16'(i)) begin
              reg_data_out = cfg_delay[i*8 +: 8];
            end
          end
        end
        ADDR_WIDTH: begin
          for (int i = 0; i < WIDTH_B; i++) begin
            if (reg_bytecount == 16'(i)) begin
              reg_data_out = cfg_width[i*8 +: 8];
            end
          end
        end
        ADDR_GAP: begin
          for (int i = 0; i < WIDTH_B; i++) begin
            if (reg_bytecount == 16'(i)) begin
              reg_data_out = cfg_gap[i*8 +: 8];
            end
          end
        end
        ADDR_COUNT: begin
          if (reg_bytecount == 16'd0) begin
            reg_data_out = cfg_count;
          end
        end
        default: begin
          reg_data_out = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Bench for trigger_pulse_generator: directed scenarios plus random traffic,
// checked every cycle against a schedule-based behavioural model.
module tb_trigger_pulse_generator;

  localparam logic [7:0] A_CTRL  = 8'h50;
  localparam logic [7:0] A_DELAY = 8'h51;
  localparam logic [7:0] A_WIDTH = 8'h52;
  localparam logic [7:0] A_GAP   = 8'h53;
  localparam logic [7:0] A_COUNT = 8'h54;

  logic        sampleclk = 1'b0;
  logic        reset;
  logic        trigger_in;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;
  logic        pulse_out;
  logic        armed;
  logic        busy;

  trigger_pulse_generator #(.DELAY_W(32), .WIDTH_W(16)) dut (
    .sampleclk    (sampleclk),
    .reset        (reset),
    .trigger_in   (trigger_in),
    .reg_cmd      (reg_cmd),
    .reg_bytecount(reg_bytecount),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .pulse_out    (pulse_out),
    .armed        (armed),
    .busy         (busy)
  );

  always #5 sampleclk = ~sampleclk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // behavioural model: a train is a closed-form schedule of absolute cycles
  longint      cyc = 0;
  bit          m_armed, m_train, m_done, m_auto;
  longint      m_first, m_f, m_per, m_w;
  logic [31:0] m_delay;
  logic [15:0] m_width, m_gap;
  logic [7:0]  m_count;
  int          rises = 0;
  logic        prev_pulse = 1'b0;

  function automatic longint eff(input longint v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic m_pulse(input longint c);
    return m_train && (c >= m_first) && (((c - m_first) % m_per) < m_w);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] cmd, input logic [15:0] n);
    logic [7:0] r;
    r = 8'h00;
    case (cmd)
      A_CTRL:  if (n == 16'd0) r = {4'b0000, m_done, m_auto, m_train, m_armed};
      A_DELAY: if (n < 16'd4) r = 8'(m_delay >> (8 * n));
      A_WIDTH: if (n < 16'd2) r = 8'(m_width >> (8 * n));
      A_GAP:   if (n < 16'd2) r = 8'(m_gap >> (8 * n));
      A_COUNT: if (n == 16'd0) r = m_count;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    longint n;
    bit busy_c, armed_c, cw, abort, arm;
    int b;
    n       = cyc + 1;
    busy_c  = m_train;
    armed_c = m_armed;
    cw      = reg_write && (reg_cmd == A_CTRL) && (reg_bytecount == 16'd0);
    abort   = cw && reg_data_in[1];
    arm     = cw && reg_data_in[0] && !reg_data_in[1];
    b       = int'(reg_bytecount);
    if (reset) begin
      m_armed = 0; m_train = 0; m_done = 0; m_auto = 0;
      m_delay = 0; m_width = 1; m_gap = 1; m_count = 1;
    end else begin
      if (abort && (busy_c || armed_c)) begin
        m_train = 0;
        m_armed = 0;
      end else begin
        if (busy_c && (n == m_f)) begin
          m_train = 0;
          m_done  = 1;
          m_armed = m_auto;
        end
        if (armed_c && trigger_in) begin
          m_first = n + longint'(m_delay);
          m_w     = eff(longint'(m_width));
          m_per   = m_w + eff(longint'(m_gap));
          m_f     = m_first + (eff(longint'(m_count)) - 1) * m_per + m_w;
          m_train = 1;
          m_armed = 0;
        end
        if (arm && !busy_c && !armed_c) begin
          m_armed = 1;
          m_done  = 0;
        end
      end
      if (cw) m_auto = reg_data_in[2];
      if (reg_write && !busy_c) begin
        case (reg_cmd)
          A_DELAY: if (b < 4) m_delay[b*8 +: 8] = reg_data_in;
          A_WIDTH: if (b < 2) m_width[b*8 +: 8] = reg_data_in;
          A_GAP:   if (b < 2) m_gap[b*8 +: 8] = reg_data_in;
          A_COUNT: if (b == 0) m_count = reg_data_in;
          default: ;
        endcase
      end
    end
    cyc = n;
  endtask

  // one clock: advance the model across the edge, then compare status outputs
  task automatic step();
    @(posedge sampleclk);
    model_edge();
    #1;
    check_eq("pulse_out", pulse_out, m_pulse(cyc));
    check_eq("armed", armed, m_armed);
    check_eq("busy", busy, m_train);
    if (pulse_out && !prev_pulse) rises++;
    prev_pulse = pulse_out;
  endtask

  task automatic rd(input logic [7:0] cmd, input logic [15:0] n, output logic [7:0] d);
    reg_read = 1'b1; reg_cmd = cmd; reg_bytecount = n;
    #1;
    d = reg_data_out;
    check_eq("rd_model", d, m_read(cmd, n));
    reg_read = 1'b0;
  endtask

  task automatic wr(input logic [7:0] cmd, input logic [15:0] n, input logic [7:0] d);
    reg_write = 1'b1; reg_cmd = cmd; reg_bytecount = n; reg_data_in = d;
    step();
    reg_write = 1'b0;
  endtask

  task automatic trig();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
  endtask

  logic [7:0]  d;
  logic [31:0] mask;
  longint      t0;
  longint      found;

  initial begin
    reset = 1'b1; trigger_in = 1'b0; reg_cmd = 8'h00; reg_bytecount = 16'd0;
    reg_data_in = 8'h00; reg_read = 1'b0; reg_write = 1'b0;
    step(); step();
    reset = 1'b0;

    // reset state
    check_eq("rst_pulse", pulse_out, 1'b0);
    check_eq("rst_armed", armed, 1'b0);
    rd(A_CTRL, 0, d);  check_eq("rst_ctrl", d, 8'h00);
    rd(A_WIDTH, 0, d); check_eq("rst_width", d, 8'h01);
    rd(A_GAP, 0, d);   check_eq("rst_gap", d, 8'h01);
    rd(A_COUNT, 0, d); check_eq("rst_count", d, 8'h01);
    rd(8'h77, 0, d);   check_eq("rd_unknown", d, 8'h00);

    // defaults: single one-cycle pulse right after trigger
    wr(A_CTRL, 0, 8'h01);
    check_eq("arm_next", armed, 1'b1);
    trig();
    check_eq("t1_rise", pulse_out, 1'b1);
    step();
    check_eq("t1_fall", pulse_out, 1'b0);
    rd(A_CTRL, 0, d); check_eq("t1_ctrl", d, 8'h08);

    // delay 10, width 3, gap 2, count 3
    wr(A_DELAY, 0, 8'd10); wr(A_WIDTH, 0, 8'd3); wr(A_GAP, 0, 8'd2); wr(A_COUNT, 0, 8'd3);
    wr(A_CTRL, 0, 8'h01);
    mask = '0;
    t0 = cyc;
    trig();
    for (int k = 0; k < 30; k++) begin
      if (pulse_out) mask[cyc - t0] = 1'b1;
      step();
    end
    check_eq("t2_mask", mask, 32'h00E7_3800);
    rd(A_CTRL, 0, d); check_eq("t2_ctrl", d, 8'h08);

    // triggers while idle and during delay are dropped
    rises = 0;
    trig(); step(); step();
    check_eq("t3_idle_busy", busy, 1'b0);
    wr(A_CTRL, 0, 8'h01);
    trig(); step(); step(); step();
    trig();
    repeat (30) step();
    check_eq("t3_rises", rises, 3);

    // abort mid-pulse; config writes blocked while busy
    wr(A_DELAY, 0, 8'd0); wr(A_WIDTH, 0, 8'd100); wr(A_COUNT, 0, 8'd1);
    wr(A_CTRL, 0, 8'h01);
    trig(); repeat (5) step();
    wr(A_DELAY, 0, 8'd5);
    rd(A_DELAY, 0, d); check_eq("t4_delay_kept", d, 8'h00);
    wr(A_CTRL, 0, 8'h02);
    check_eq("t4_abort_pulse", pulse_out, 1'b0);
    check_eq("t4_abort_busy", busy, 1'b0);
    rd(A_CTRL, 0, d); check_eq("t4_ctrl", d, 8'h00);

    // auto-rearm: two accepted triggers, one ignored mid-train
    wr(A_WIDTH, 0, 8'd2); wr(A_GAP, 0, 8'd1); wr(A_DELAY, 0, 8'd3);
    wr(A_CTRL, 0, 8'h05);
    rises = 0;
    t0 = cyc;
    trig(); step(); step();
    trig();
    while (cyc < t0 + 20) step();
    check_eq("t5_rearmed", armed, 1'b1);
    trig();
    repeat (10) step();
    check_eq("t5_rises", rises, 2);
    wr(A_CTRL, 0, 8'h02);

    // multi-byte delay
    wr(A_DELAY, 0, 8'h01); wr(A_DELAY, 1, 8'h02); wr(A_DELAY, 2, 8'h00); wr(A_DELAY, 3, 8'h00);
    wr(A_DELAY, 4, 8'hFF); wr(A_WIDTH, 0, 8'd1);
    rd(A_DELAY, 0, d); check_eq("t6_b0", d, 8'h01);
    rd(A_DELAY, 1, d); check_eq("t6_b1", d, 8'h02);
    rd(A_DELAY, 2, d); check_eq("t6_b2", d, 8'h00);
    rd(A_DELAY, 3, d); check_eq("t6_b3", d, 8'h00);
    rd(A_DELAY, 4, d); check_eq("t6_b4", d, 8'h00);
    wr(A_CTRL, 0, 8'h01);
    t0 = cyc;
    trig();
    while (!pulse_out && (cyc < t0 + 600)) step();
    found = pulse_out ? (cyc - t0) : -1;
    check_eq("t6_first", found, 64'd514);
    repeat (3) step();

    // random traffic against the model
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) rd(8'(8'h50 + $urandom_range(0, 5)), 16'($urandom_range(0, 4)), d);
      trigger_in = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      reg_write  = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        int sel;
        int r;
        sel = $urandom_range(0, 4);
        reg_write = 1'b1;
        reg_bytecount = 16'd0;
        reg_cmd = 8'(8'h50 + sel);
        r = $urandom_range(0, 9);
        case (sel)
          0: begin
            reg_data_in = (r < 6) ? 8'h01 : (r < 8) ? 8'h02 : (r == 8) ? 8'h03 : 8'h00;
            reg_data_in[2] = 1'($urandom_range(0, 1));
          end
          1: reg_data_in = 8'($urandom_range(0, 15));
          2: reg_data_in = 8'($urandom_range(0, 5));
          3: reg_data_in = 8'($urandom_range(0, 4));
          default: reg_data_in = 8'($urandom_range(0, 4));
        endcase
        if ((sel != 0) && (r == 9)) begin
          reg_bytecount = 16'(4 + $urandom_range(0, 2));
          reg_data_in   = 8'($urandom_range(0, 255));
        end
      end
      step();
    end
    reg_write = 1'b0; trigger_in = 1'b0; reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_pulse_generator.md
# trigger_pulse_generator

Downstream consumer of the digital edge detector's `trigger` output. Once armed, it waits for a trigger, counts a programmable delay, then emits a train of programmable-width pulses on `pulse_out` (glitch/capture strobe). Delay, width, gap, pulse count and arm/abort control are programmed over the serial register interface. Everything runs on `sampleclk`.

## Interface
Parameters:
- `DELAY_W`, 32: width of delay counter/register (multiple of 8).
- `WIDTH_W`, 16: width of pulse-width and gap registers (multiple of 8).

Ports:
- `sampleclk`  in  1  sole clock; register interface and trigger are synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `trigger_in`  in  1  single-cycle trigger strobe from edge detector.
- `reg_cmd`  in  8  register address.
- `reg_bytecount`  in  16  byte index within multi-byte register (0 = LSB).
- `reg_data_in`  in  8  write data.
- `reg_data_out`  out  8  read data, combinational.
- `reg_read`  in  1  read strobe.
- `reg_write`  in  1  write strobe.
- `pulse_out`  out  1  generated pulse train, registered.
- `armed`  out  1  high in ARMED state.
- `busy`  out  1  high in DELAY, PULSE or GAP.

## Operation
- Registers (byte `n` = `reg_bytecount`, little-endian; `n` beyond register width ignored on write, reads 0):
  - 50 CTRL (1 byte): write bit0=1 arm, bit1=1 abort, bit2 = auto-rearm (stored). Read: bit0 armed, bit1 busy, bit2 auto-rearm, bit3 done (sticky, cleared by arm write).
  - 51 DELAY (`DELAY_W`), 52 WIDTH (`WIDTH_W`), 53 GAP (`WIDTH_W`), 54 COUNT (8 bits).
  - Unknown `reg_cmd`, or `reg_read` low: `reg_data_out` = 0.
- Writes to 51-54 are ignored while `busy`; accepted in IDLE/ARMED.
- Effective values: WIDTH 0 -> 1, GAP 0 -> 1, COUNT 0 -> 1. DELAY 0 is legal.
- FSM:
  - IDLE: arm write -> ARMED, clear done.
  - ARMED: `trigger_in`=1 -> DELAY (or PULSE directly if DELAY=0), load counters. Arm write in ARMED: no effect.
  - DELAY: count DELAY cycles -> PULSE.
  - PULSE: `pulse_out`=1 for WIDTH cycles; then if pulses remaining -> GAP, else finish.
  - GAP: `pulse_out`=0 for GAP cycles -> PULSE.
  - Finish: set done; auto-rearm=1 -> ARMED, else IDLE.
- Abort write (any non-IDLE state): next state IDLE, `pulse_out` low next cycle, done not set. Abort and arm both set in one write: abort wins, result IDLE.
- Triggers outside ARMED are ignored (no queuing).
- Config latched into working counters at trigger; register changes never affect a train in flight.
- Counters saturate-free: DELAY counts full `DELAY_W` range (max 2^DELAY_W-1 cycles).

## Timing
- Reset: state IDLE, `pulse_out`=0, `armed`=0, `busy`=0, DELAY=0, WIDTH=1, GAP=1, COUNT=1, auto-rearm=0, done=0.
- Register write takes effect the cycle after `reg_write`; arm write at cycle c -> `armed`=1 at c+1; trigger accepted from c+1.
- Trigger high at cycle t in ARMED: `armed` low at t+1; first `pulse_out` rising edge at t+1+DELAY.
- Pulse k (0-based) rises at t+1+DELAY+k*(WIDTH+GAP), high exactly WIDTH cycles.
- Last pulse falls at cycle f; at f: `busy`=0, done=1, `armed`=1 if auto-rearm; a trigger at f+... accepted from f onward only when `armed`=1.
- `busy` and `pulse_out` never both change due to a register write except abort.
- Reset mid-train: `pulse_out` low next cycle, all config back to defaults.

## Test plan
- Defaults, arm, trigger at t -> `pulse_out` high exactly cycle t+1, one pulse, done=1, `armed`=0.
- DELAY=10, WIDTH=3, GAP=2, COUNT=3, trigger at t -> pulses high t+11..t+13, t+16..t+18, t+21..t+23; CTRL read = 0x08 after.
- Trigger while IDLE and during DELAY -> ignored; exactly one train from armed trigger.
- Abort during PULSE (WIDTH=100) -> `pulse_out` low next cycle, state IDLE, done=0; write DELAY=5 during busy -> readback unchanged.
- Auto-rearm=1, COUNT=1: two triggers 20 cycles apart -> two pulses; second trigger during the first train -> ignored.
- Multi-byte DELAY write bytes 0..3 = 0x01,0x02,0x00,0x00 -> readback 0x01,0x02,0,0; first pulse at t+1+513.
